adc_frame_assembler: RTL

//  Collects one ADC conversion frame, word by word, from the SPI word shifter.

---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_word_extend.sv | 20 ++
 rtl/adc_frame_assembler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared frame geometry, extension mask and state encoding for the ADC frame path.
package adc_pkg;

    localparam int                             ADC_WORDS_PER_FRAME = 10;
    localparam int                             ADC_WORD_BITS       = 24;
    localparam logic [ADC_WORDS_PER_FRAME-1:0] ADC_SEXT_MASK       = 10'h1FE;
    localparam int                             ADC_TIMEOUT_CYC     = 1024;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } adc_state_e;

endpackage

// File: rtl/adc_word_extend.sv
// Widens one raw ADC word to 32 bits, sign- or zero-filled.
// Latency: combinational.
// Backpressure: none.
module adc_word_extend #(
    parameter int WORD_BITS = 24,
    parameter bit SIGNED    = 1'b0
) (
    input  logic [WORD_BITS-1:0] word_i,
    output logic [31:0]          word_o
);

    generate
        if (WORD_BITS >= 32) begin : g_full
            assign word_o = word_i[31:0];
        end else begin : g_ext
            assign word_o = {{(32-WORD_BITS){SIGNED ? word_i[WORD_BITS-1] : 1'b0}}, word_i};
        end
    endgenerate

endmodule

// File: rtl/adc_frame_assembler.sv
// Collects one ADC frame word by word and publishes it as a flat 32-bit-per-word bus.
// Latency: frame_end sampled at edge N gives frame_valid during cycle N+1.
// Backpressure: none; never stalls, downstream drops frames itself.
module adc_frame_assembler
    import adc_pkg::*;
#(
    parameter int               WORDS       = ADC_WORDS_PER_FRAME,
    parameter int               WORD_BITS   = ADC_WORD_BITS,
    parameter logic [WORDS-1:0] SEXT_MASK   = ADC_SEXT_MASK,
    parameter int               TIMEOUT_CYC = ADC_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    frame_end,
    input  logic                    word_valid,
    input  logic [WORD_BITS-1:0]    word_data,
    output logic                    frame_valid,
    output logic [32*WORDS-1:0]     frame_words_packed,
    output logic [15:0]             frame_count,
    output logic                    busy,
    output logic                    err_short,
    output logic                    err_long,
    output logic                    err_timeout
);

    localparam int IW = $clog2(WORDS + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    adc_state_e          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, idx_after;
    logic [TW-1:0]       timer_q, timer_d;
    logic                ovf_q, ovf_d, ovf_after;
    logic [32*WORDS-1:0] shadow_q, shadow_d, shadow_after;
    logic [32*WORDS-1:0] out_q, out_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                frame_valid_q, frame_valid_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic                err_timeout_q, err_timeout_d;

    logic [31:0]         ext_w [WORDS];

    // Each slot has a fixed extension rule, so one extender per slot, muxed on idx.
    generate
        for (genvar w = 0; w < WORDS; w++) begin : g_ext
            adc_word_extend #(
                .WORD_BITS (WORD_BITS),
                .SIGNED    (SEXT_MASK[w])
            ) u_ext (
                .word_i (word_data),
                .word_o (ext_w[w])
            );
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        ovf_d         = ovf_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_count_d = frame_count_q;
        frame_valid_d = 1'b0;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        err_timeout_d = 1'b0;

        // A word arriving with frame_start belongs to the new frame, not the old one.
        idx_after    = idx_q;
        ovf_after    = ovf_q;
        shadow_after = shadow_q;
        if (state_q == ST_COLLECT && word_valid && !frame_start) begin
            if (idx_q < IW'(WORDS)) begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IW'(w)) begin
                        shadow_after[32*w +: 32] = ext_w[w];
                    end
                end
                idx_after = idx_q + IW'(1);
            end else begin
                ovf_after = 1'b1;
            end
        end

        if (state_q == ST_COLLECT) begin
            idx_d    = idx_after;
            ovf_d    = ovf_after;
            shadow_d = shadow_after;
            timer_d  = timer_q + TW'(1);
            if (frame_end) begin
                state_d = ST_IDLE;
                if (ovf_after) begin
                    err_long_d = 1'b1;
                end else if (idx_after < IW'(WORDS)) begin
                    err_short_d = 1'b1;
                end else begin
                    out_d         = shadow_after;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end else if (frame_start) begin
                err_short_d = 1'b1;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = ST_IDLE;
            end
        end

        // Start is applied last so an end on the same cycle closes the old frame first.
        if (frame_start) begin
            state_d = ST_COLLECT;
            timer_d = '0;
            ovf_d   = 1'b0;
            idx_d   = word_valid ? IW'(1) : '0;
            if (word_valid) begin
                shadow_d[31:0] = ext_w[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            ovf_q         <= 1'b0;
            shadow_q      <= '0;
            out_q         <= '0;
            frame_count_q <= '0;
            frame_valid_q <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            ovf_q         <= ovf_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_count_q <= frame_count_d;
            frame_valid_q <= frame_valid_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign frame_valid        = frame_valid_q;
    assign frame_words_packed = out_q;
    assign frame_count        = frame_count_q;
    assign busy               = (state_q == ST_COLLECT);
    assign err_short          = err_short_q;
    assign err_long           = err_long_q;
    assign err_timeout        = err_timeout_q;

endmodule
